// File: rtl/gpio_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_access_arbiter_if
// Description : Requester handshake and GPIO Avalon-MM slave bundle for the
//               arbiter. Modport slave is the arbiter view; master is the
//               surrounding requesters plus the GPIO slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_access_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 28
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [3*NUM_REQ-1:0]          req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic [1:0]                    gpio_address;
  logic                          gpio_chipselect;
  logic                          gpio_write_n;
  logic [31:0]                   gpio_writedata;
  logic [31:0]                   gpio_readdata;

  modport slave (
    input  req_valid, req_op, req_data, req_lock, gpio_readdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           gpio_address, gpio_chipselect, gpio_write_n, gpio_writedata
  );

  modport master (
    output req_valid, req_op, req_data, req_lock, gpio_readdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           gpio_address, gpio_chipselect, gpio_write_n, gpio_writedata
  );
endinterface
`default_nettype wire

// File: rtl/gpio_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_access_arbiter
// Description : Round-robin arbiter sharing one GPIO Avalon-MM slave, with
//               shadow out/dir registers for atomic set/clear/toggle.
//               Optional macro GPIO_ACCESS_ARBITER_LOCK_EN adds requester lock.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  gpio_access_arbiter_if.slave bus
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] c_OP_RD_IN   = 3'd0;
  localparam logic [2:0] c_OP_RD_DIR  = 3'd1;
  localparam logic [2:0] c_OP_WR_OUT  = 3'd2;
  localparam logic [2:0] c_OP_SET_OUT = 3'd3;
  localparam logic [2:0] c_OP_CLR_OUT = 3'd4;
  localparam logic [2:0] c_OP_TOG_OUT = 3'd5;
  localparam logic [2:0] c_OP_WR_DIR  = 3'd6;
  localparam logic [2:0] c_OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [c_IDX_W-1:0]    rr_q;
  logic [c_IDX_W-1:0]    owner_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] shadow_out_q;
  logic [DATA_WIDTH-1:0] shadow_dir_q;
  logic [1:0]            gpio_address_q;
  logic                  gpio_chipselect_q;
  logic                  gpio_write_n_q;
  logic [31:0]           gpio_writedata_q;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_found;
  logic [c_IDX_W-1:0]    w_win;
  logic                  w_accept;
  logic [2:0]            w_op;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  w_op_read;
  logic                  w_op_dir;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic                  w_unused;

`ifdef GPIO_ACCESS_ARBITER_LOCK_EN
  logic lock_q;
  logic acc_lock_q;

  // While locked, owner_q still names the requester that took the lock.
  always_comb begin
    w_elig = bus.req_valid;
    if (lock_q) begin
      w_elig = bus.req_valid & (NUM_REQ'(1) << owner_q);
    end
  end
`else
  always_comb begin
    w_elig = bus.req_valid;
  end
`endif

  always_comb begin : p_arb
    logic [c_IDX_W-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = c_IDX_W'((int'(rr_q) + i) % NUM_REQ);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_accept  = (state_q == ST_IDLE) && w_found;
  assign w_op      = bus.req_op[int'(w_win) * 3 +: 3];
  assign w_dat     = bus.req_data[int'(w_win) * DATA_WIDTH +: DATA_WIDTH];
  assign w_op_read = (w_op == c_OP_RD_IN) || (w_op == c_OP_RD_DIR);
  assign w_op_dir  = (w_op == c_OP_RD_DIR) || (w_op == c_OP_WR_DIR);

  // New register value, computed from the shadow so no read-back is needed.
  always_comb begin
    wdata_d = '0;
    case (w_op)
      c_OP_WR_OUT:  wdata_d = w_dat;
      c_OP_SET_OUT: wdata_d = shadow_out_q | w_dat;
      c_OP_CLR_OUT: wdata_d = shadow_out_q & ~w_dat;
      c_OP_TOG_OUT: wdata_d = shadow_out_q ^ w_dat;
      c_OP_WR_DIR:  wdata_d = w_dat;
      default:      wdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      rr_q              <= c_IDX_W'(NUM_REQ - 1);
      owner_q           <= '0;
      op_q              <= '0;
      wdata_q           <= '0;
      shadow_out_q      <= '0;
      shadow_dir_q      <= '0;
      gpio_address_q    <= '0;
      gpio_chipselect_q <= 1'b0;
      gpio_write_n_q    <= 1'b1;
      gpio_writedata_q  <= '0;
`ifdef GPIO_ACCESS_ARBITER_LOCK_EN
      lock_q            <= 1'b0;
      acc_lock_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            owner_q <= w_win;
            rr_q    <= w_win;
            op_q    <= w_op;
            wdata_q <= wdata_d;
`ifdef GPIO_ACCESS_ARBITER_LOCK_EN
            acc_lock_q <= bus.req_lock[w_win];
            if (bus.req_lock[w_win]) begin
              lock_q <= 1'b1;
            end
`endif
            if (w_op == c_OP_ILLEGAL) begin
              state_q <= ST_DONE;
            end else begin
              state_q           <= ST_ISSUE;
              gpio_chipselect_q <= 1'b1;
              gpio_write_n_q    <= w_op_read;
              gpio_address_q    <= {1'b0, w_op_dir};
              gpio_writedata_q  <= w_op_read ? 32'd0 : 32'(wdata_d);
            end
          end
        end
        ST_ISSUE: begin
          case (op_q)
            c_OP_WR_OUT, c_OP_SET_OUT,
            c_OP_CLR_OUT, c_OP_TOG_OUT: shadow_out_q <= wdata_q;
            c_OP_WR_DIR:                shadow_dir_q <= wdata_q;
            default:                    ;
          endcase
          gpio_chipselect_q <= 1'b0;
          gpio_write_n_q    <= 1'b1;
          gpio_address_q    <= '0;
          gpio_writedata_q  <= '0;
          state_q           <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
`ifdef GPIO_ACCESS_ARBITER_LOCK_EN
          if (!acc_lock_q) begin
            lock_q <= 1'b0;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data is only valid in DONE, after the slave's readdata register loads.
  always_comb begin
    w_rsp_data = '0;
    if (state_q == ST_DONE) begin
      case (op_q)
        c_OP_RD_IN, c_OP_RD_DIR: w_rsp_data = bus.gpio_readdata[DATA_WIDTH-1:0];
        c_OP_WR_DIR:             w_rsp_data = shadow_dir_q;
        c_OP_ILLEGAL:            w_rsp_data = '0;
        default:                 w_rsp_data = shadow_out_q;
      endcase
    end
  end

  assign bus.req_ready       = w_accept ? (NUM_REQ'(1) << w_win) : '0;
  assign bus.rsp_valid       = (state_q == ST_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.rsp_err         = (state_q == ST_DONE) && (op_q == c_OP_ILLEGAL);
  assign bus.rsp_data        = w_rsp_data;
  assign bus.gpio_address    = gpio_address_q;
  assign bus.gpio_chipselect = gpio_chipselect_q;
  assign bus.gpio_write_n    = gpio_write_n_q;
  assign bus.gpio_writedata  = gpio_writedata_q;

  assign w_unused = ^{bus.req_lock, bus.gpio_readdata};

endmodule
`default_nettype wire

// File: doc/gpio_access_arbiter.md
Name: gpio_access_arbiter

Overview:
Shares one 28-bit bidirectional GPIO Avalon-MM slave among NUM_REQ requesters, using round-robin arbitration and a one-outstanding-operation FSM.
- Keeps shadow copies of the GPIO output and direction registers. The slave's output register is not readable, so the shadows let the block do atomic bit set, clear and toggle without read-modify-write races.
- Sits between the CPU-side or hardware requesters and the GPIO slave port.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
DATA_WIDTH, 28, GPIO width. Must match the slave's bidir_port width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request strobe; held until accepted
req_op  in  3*NUM_REQ  per-requester opcode, requester i at bits [3i+2:3i]
req_data  in  DATA_WIDTH*NUM_REQ  per-requester operand
req_lock  in  NUM_REQ  per-requester lock hint; used only with the optional feature
req_ready  out  NUM_REQ  one-cycle accept pulse to the winner
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
rsp_data  out  DATA_WIDTH  shared response data
rsp_err  out  1  qualifies rsp_valid; 1 = illegal opcode
gpio_address  out  2  to slave address
gpio_chipselect  out  1  to slave chipselect
gpio_write_n  out  1  to slave write_n
gpio_writedata  out  32  to slave writedata; bits above DATA_WIDTH are 0
gpio_readdata  in  32  from slave readdata

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low (reset_n). Reset forces:
  - state IDLE;
  - shadow_out = 0 and shadow_dir = 0, matching the slave's reset values;
  - rr pointer = NUM_REQ-1;
  - all outputs 0, except gpio_write_n = 1.
  Reset asserted mid-operation abandons the operation: no rsp_valid is issued, and the requester must re-request.
- Opcodes:
  - 0 RD_IN: read address 0.
  - 1 RD_DIR: read address 1.
  - 2 WR_OUT: out = d.
  - 3 SET_OUT: out = shadow_out | d.
  - 4 CLR_OUT: out = shadow_out & ~d.
  - 5 TOG_OUT: out = shadow_out ^ d.
  - 6 WR_DIR: dir = d.
  - 7: illegal.
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - If any req_valid is high, the winner is the first requester with req_valid high, searching from (rr+1) mod NUM_REQ upward with wrap.
  - In the same cycle: req_ready[winner] = 1 (combinational), op/data/owner are latched, rr <= winner, and the state goes to ISSUE.
  - For op 7, the state goes directly to DONE with err set.
- ISSUE (one cycle, gpio_* outputs registered):
  - Writes: address 0 (ops 2-5) or 1 (op 6), chipselect = 1, write_n = 0, writedata = new value. The matching shadow updates at the end of this cycle.
  - Reads: address = 0 or 1, chipselect = 1, write_n = 1. The slave's readdata register loads at the end of this cycle.
- DONE (one cycle):
  - rsp_valid[owner] = 1.
  - rsp_data = gpio_readdata[DATA_WIDTH-1:0] for reads, the updated shadow value for writes, 0 for op 7.
  - rsp_err = 1 only for op 7.
  - gpio_chipselect = 0, gpio_write_n = 1. Next state IDLE.
- Latency: accept to response is 2 cycles. Peak throughput is one operation per 3 cycles.
- Outside DONE, rsp_valid = 0 and rsp_data and rsp_err hold 0.
- Simultaneous req_valid from several requesters: exactly one req_ready per IDLE cycle; losers keep req_valid high.
- A requester may re-assert req_valid in its DONE cycle. It is considered in the next IDLE cycle.
- Shadow arithmetic is bitwise at DATA_WIDTH bits; there is no carry or wrap.

Optional Feature:
GPIO_ACCESS_ARBITER_LOCK_EN:
- Defined: if the winner has req_lock high at acceptance, the arbiter is locked to that requester. While locked, only that requester can win; others get no req_ready even when it idles. The lock releases at DONE of an operation that was accepted with req_lock low. Reset clears the lock.
- Undefined: req_lock is ignored and arbitration is pure round-robin.

Test Plan:
- Reset release, req_valid[0] with RD_IN, pins = 0x0ABCDEF -> req_ready[0] in cycle 0; address 0 read in cycle 1; rsp_valid[0] with rsp_data = 0x0ABCDEF in cycle 2.
- WR_DIR 0xFFFFFFF, then WR_OUT 0x00000F0, SET_OUT 0x000000F, CLR_OUT 0x0000030, TOG_OUT 0x0000101 -> writedata sequence 0xFFFFFFF, 0x00000F0, 0x00000FF, 0x00000CF, 0x00001CE; pins match.
- req_valid[0] and req_valid[1] held high continuously for 4 ops -> grants 0,1,0,1; each op spans 3 cycles.
- Op 7 from requester 1 -> no chipselect; rsp_valid[1] with rsp_err = 1 and rsp_data = 0 one cycle after accept.
- reset_n pulsed low during ISSUE of SET_OUT -> no rsp_valid; shadow_out = 0; next SET_OUT 0x1 writes 0x0000001.
- With the macro: req 0 locks, req 1 waiting, req 0 idles 5 cycles -> no grant to 1; after an unlocked op 0 completes, req 1 is granted. Without the macro: req 1 is granted immediately.
